// File: rtl/picorv32_demo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_demo_pkg
// Brief    : Shared constants and types for the PicoRV32 demo memory fabric.
// Revision : 1.0 - initial release
// ============================================================================
package picorv32_demo_pkg;

  // Arbiter FSM encoding
  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_BUSY = 1'b1;

  // Watchdog defaults
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
  localparam logic [31:0] DEFAULT_TIMEOUT_RDATA  = 32'hDEAD_BEEF;

  // Master indices (also the value of the grant / owner signal)
  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_AUX = 1'b1;

  // Request payload that travels with valid from a master to the slave
  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  // Round-robin pick: on a tie the master that did not win last time wins,
  // otherwise the sole requester wins.
  function automatic logic arb_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
      return ~last;
    end
    return v1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : bus_watchdog
// Brief    : Saturating cycle counter with clear/enable; expired_o is high
//            while the count sits at TIMEOUT_CYCLES-1. TIMEOUT_CYCLES=0
//            disables it (expired_o tied low).
// Revision : 1.0 - initial release
// ============================================================================
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      // Inputs are intentionally ignored when the watchdog is compiled out
      logic w_unused;
      assign w_unused  = &{1'b0, clk_i, rst_n_i, clear_i, enable_i};
      assign expired_o = 1'b0;
    end else begin : g_enabled
      localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] count_q;
      logic [CW-1:0] count_d;

      // Next count: clear has priority, then count up and hold at the limit
      always_comb begin
        count_d = count_q;
        if (clear_i) begin
          count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
          count_d = count_q + 1'b1;
        end
      end

      // Count register
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign expired_o = (count_q == LIMIT);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/picorv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_mem_arbiter
// Brief    : Two-master / one-slave round-robin arbiter for the PicoRV32
//            native memory bus, with a response watchdog that completes
//            accesses the slave never acknowledges.
// Revision : 1.0 - initial release
// ============================================================================
module picorv32_mem_arbiter
  import picorv32_demo_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [31:0] TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // master 0 (CPU)
  input  logic        m0_valid_i,
  input  logic        m0_instr_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic        m0_ready_o,
  output logic [31:0] m0_rdata_o,
  // master 1 (auxiliary)
  input  logic        m1_valid_i,
  input  logic        m1_instr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic        m1_ready_o,
  output logic [31:0] m1_rdata_o,
  // slave
  output logic        s_valid_o,
  output logic        s_instr_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_wstrb_o,
  input  logic        s_ready_i,
  input  logic [31:0] s_rdata_i,
  // status
  output logic        owner_o,
  output logic        timeout_o
);

  logic [0:0] state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;

  logic       w_busy;
  logic       w_expired;
  logic       w_sel0, w_sel1;
  logic       w_to0, w_to1;
  logic       w_sel_valid;
  mem_req_t   w_req0, w_req1, w_sel;

  assign w_busy = (state_q == ARB_BUSY);
  assign w_sel0 = w_busy && (grant_q == MASTER_CPU);
  assign w_sel1 = w_busy && (grant_q == MASTER_AUX);

  assign w_req0 = '{instr: m0_instr_i, addr: m0_addr_i, wdata: m0_wdata_i, wstrb: m0_wstrb_i};
  assign w_req1 = '{instr: m1_instr_i, addr: m1_addr_i, wdata: m1_wdata_i, wstrb: m1_wstrb_i};
  assign w_sel       = (grant_q == MASTER_AUX) ? w_req1 : w_req0;
  assign w_sel_valid = (grant_q == MASTER_AUX) ? m1_valid_i : m0_valid_i;

  // Counter runs only while an access is outstanding; every IDLE cycle rearms it
  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (~w_busy),
    .enable_i  (w_busy),
    .expired_o (w_expired)
  );

  // A timeout is only declared when the slave is silent in the expiry cycle;
  // a simultaneous s_ready_i is treated as a normal completion. Each master's
  // terms use only its own inputs so the masters never see each other.
  assign w_to0 = w_sel0 && m0_valid_i && !s_ready_i && w_expired;
  assign w_to1 = w_sel1 && m1_valid_i && !s_ready_i && w_expired;

  assign m0_ready_o = w_sel0 && m0_valid_i && (s_ready_i || w_expired);
  assign m1_ready_o = w_sel1 && m1_valid_i && (s_ready_i || w_expired);
  assign m0_rdata_o = w_sel0 ? (w_to0 ? TIMEOUT_RDATA : s_rdata_i) : 32'h0;
  assign m1_rdata_o = w_sel1 ? (w_to1 ? TIMEOUT_RDATA : s_rdata_i) : 32'h0;
  assign timeout_o  = w_to0 || w_to1;

  // Slave side is a plain mux of the granted master; quiet in IDLE and
  // withdrawn in the timeout cycle so the slave sees the access abandoned.
  assign s_valid_o = w_busy && w_sel_valid && !timeout_o;
  assign s_instr_o = w_busy ? w_sel.instr : 1'b0;
  assign s_addr_o  = w_busy ? w_sel.addr  : 32'h0;
  assign s_wdata_o = w_busy ? w_sel.wdata : 32'h0;
  assign s_wstrb_o = w_busy ? w_sel.wstrb : 4'h0;

  assign owner_o = grant_q;

  // Next-state: arbitrate in IDLE, leave BUSY on completion, timeout or a
  // withdrawn request
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_valid_i || m1_valid_i) begin
          grant_d      = arb_pick(m0_valid_i, m1_valid_i, last_grant_q);
          last_grant_d = grant_d;
          state_d      = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (!w_sel_valid || s_ready_i || w_expired) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, grant and fairness history; last_grant resets to 1 so CPU wins the first tie
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ARB_IDLE;
      grant_q      <= MASTER_CPU;
      last_grant_q <= MASTER_AUX;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_picorv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_picorv32_mem_arbiter
// Brief    : Directed self-checking bench for picorv32_mem_arbiter
//            (TIMEOUT_CYCLES = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_picorv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        owner, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  picorv32_mem_arbiter #(
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_RDATA  (32'hDEAD_BEEF)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .m0_valid_i (m0_valid),
    .m0_instr_i (m0_instr),
    .m0_addr_i  (m0_addr),
    .m0_wdata_i (m0_wdata),
    .m0_wstrb_i (m0_wstrb),
    .m0_ready_o (m0_ready),
    .m0_rdata_o (m0_rdata),
    .m1_valid_i (m1_valid),
    .m1_instr_i (m1_instr),
    .m1_addr_i  (m1_addr),
    .m1_wdata_i (m1_wdata),
    .m1_wstrb_i (m1_wstrb),
    .m1_ready_o (m1_ready),
    .m1_rdata_o (m1_rdata),
    .s_valid_o  (s_valid),
    .s_instr_o  (s_instr),
    .s_addr_o   (s_addr),
    .s_wdata_o  (s_wdata),
    .s_wstrb_o  (s_wstrb),
    .s_ready_i  (s_ready),
    .s_rdata_i  (s_rdata),
    .owner_o    (owner),
    .timeout_o  (timeout)
  );

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    s_ready  = 1'b0; s_rdata  = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n    = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h44; s_ready = 1'b1; s_rdata = 32'hFFFF_FFFF;
    tick();
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rst_s_valid: got %b want 0", s_valid); end
    n_checks++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL rst_s_addr: got %h want 0", s_addr); end
    n_checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b%b want 00", m0_ready, m1_ready); end
    n_checks++; if (m0_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_m0_rdata: got %h want 0", m0_rdata); end
    n_checks++; if (owner !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL rst_status: got owner=%b timeout=%b want 0 0", owner, timeout); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h0000_0040; m0_wstrb = 4'h0;
    #1;
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rd_cycN_s_valid: got %b want 0", s_valid); end
    tick(); // N+1
    n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL rd_s_valid: got %b want 1", s_valid); end
    n_checks++; if (s_addr !== 32'h40 || s_instr !== 1'b1) begin n_fail++; $display("FAIL rd_s_req: got addr=%h instr=%b want 40 1", s_addr, s_instr); end
    n_checks++; if (owner !== 1'b0) begin n_fail++; $display("FAIL rd_owner: got %b want 0", owner); end
    for (int i = 1; i <= 3; i++) begin
      n_checks++; if (m0_ready !== 1'b0) begin n_fail++; $display("FAIL rd_wait_ready: cycle N+%0d got %b want 0", i, m0_ready); end
      tick();
    end
    // N+4: slave answers
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    n_checks++; if (m0_ready !== 1'b1) begin n_fail++; $display("FAIL rd_done_ready: got %b want 1", m0_ready); end
    n_checks++; if (m0_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_done_rdata: got %h want 12345678", m0_rdata); end
    n_checks++; if (m1_ready !== 1'b0 || m1_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_m1_quiet: got ready=%b rdata=%h want 0 0", m1_ready, m1_rdata); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (m0_ready !== 1'b0 || s_valid !== 1'b0) begin n_fail++; $display("FAIL rd_after_idle: got ready=%b s_valid=%b want 0 0", m0_ready, s_valid); end
  endtask

  task automatic test_m1_write();
    m0_addr  = 32'h0000_0999; m0_wdata = 32'h1111_2222; m0_wstrb = 4'hF;
    m1_valid = 1'b1; m1_instr = 1'b0; m1_addr = 32'h0000_0100; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'b0011;
    #1;
    tick(); // N+1
    n_checks++; if (s_valid !== 1'b1 || s_addr !== 32'h100) begin n_fail++; $display("FAIL wr_s_addr: got valid=%b addr=%h want 1 100", s_valid, s_addr); end
    n_checks++; if (s_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL wr_s_wdata: got %h want a5a5a5a5", s_wdata); end
    n_checks++; if (s_wstrb !== 4'b0011 || s_instr !== 1'b0) begin n_fail++; $display("FAIL wr_s_wstrb: got wstrb=%b instr=%b want 0011 0", s_wstrb, s_instr); end
    n_checks++; if (owner !== 1'b1 || m1_ready !== 1'b0) begin n_fail++; $display("FAIL wr_owner: got owner=%b ready=%b want 1 0", owner, m1_ready); end
    tick(); // N+2
    s_ready = 1'b1;
    #1;
    n_checks++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin n_fail++; $display("FAIL wr_done: got m1_ready=%b m0_ready=%b want 1 0", m1_ready, m0_ready); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (m1_ready !== 1'b0) begin n_fail++; $display("FAIL wr_single_pulse: got %b want 0", m1_ready); end
  endtask

  task automatic test_round_robin();
    logic exp_owner;
    logic exp_g;
    int   g0 = 0;
    int   g1 = 0;
    exp_owner = 1'b1; // last access was master 1
    m0_valid = 1'b1; m0_addr = 32'h200;
    m1_valid = 1'b1; m1_addr = 32'h300;
    s_ready  = 1'b1; s_rdata = 32'h0BAD_F00D;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      if ((k % 2) == 1) begin
        exp_g     = ((k / 2) % 2) == 1;
        exp_owner = exp_g;
        n_checks++;
        if (m0_ready !== !exp_g || m1_ready !== exp_g || s_addr !== (exp_g ? 32'h300 : 32'h200)) begin
          n_fail++;
          $display("FAIL rr_grant k=%0d: got ready=%b%b addr=%h want grant %b", k, m1_ready, m0_ready, s_addr, exp_g);
        end
        if (m0_ready === 1'b1) g0++;
        if (m1_ready === 1'b1) g1++;
      end else begin
        n_checks++;
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin n_fail++; $display("FAIL rr_idle k=%0d: got ready=%b%b want 00", k, m1_ready, m0_ready); end
      end
      n_checks++;
      if (owner !== exp_owner) begin n_fail++; $display("FAIL rr_owner k=%0d: got %b want %b", k, owner, exp_owner); end
    end
    n_checks++; if (g0 != 2 || g1 != 2) begin n_fail++; $display("FAIL rr_fairness: got m0=%0d m1=%0d want 2 2", g0, g1); end
    tick();
    idle_inputs();
    #1;
  endtask

  task automatic test_timeout();
    m0_valid = 1'b1; m0_addr = 32'h500;
    #1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_checks++;
      if (m0_ready !== 1'b0 || timeout !== 1'b0 || s_valid !== 1'b1) begin
        n_fail++; $display("FAIL to_wait N+%0d: got ready=%b timeout=%b s_valid=%b want 0 0 1", i, m0_ready, timeout, s_valid);
      end
    end
    tick(); // N+8
    n_checks++; if (m0_ready !== 1'b1 || timeout !== 1'b1) begin n_fail++; $display("FAIL to_fire: got ready=%b timeout=%b want 1 1", m0_ready, timeout); end
    n_checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_rdata: got %h want deadbeef", m0_rdata); end
    n_checks++; if (s_valid !== 1'b0 || m1_ready !== 1'b0) begin n_fail++; $display("FAIL to_s_valid: got s_valid=%b m1_ready=%b want 0 0", s_valid, m1_ready); end
    tick(); // N+9: late slave answer must be ignored
    m0_valid = 1'b0; s_ready = 1'b1; s_rdata = 32'h1111_1111;
    #1;
    n_checks++; if (m0_ready !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL to_late_ready: got ready=%b timeout=%b want 0 0", m0_ready, timeout); end
    s_ready = 1'b0;
    m1_valid = 1'b1; m1_addr = 32'h510;
    tick();
    n_checks++; if (s_valid !== 1'b1 || owner !== 1'b1 || s_addr !== 32'h510) begin n_fail++; $display("FAIL to_next_req: got s_valid=%b owner=%b addr=%h want 1 1 510", s_valid, owner, s_addr); end
    s_ready = 1'b1; s_rdata = 32'h2222_3333;
    #1;
    n_checks++; if (m1_ready !== 1'b1 || m1_rdata !== 32'h2222_3333) begin n_fail++; $display("FAIL to_next_done: got ready=%b rdata=%h want 1 22223333", m1_ready, m1_rdata); end
    tick();
    idle_inputs();
    #1;
  endtask

  task automatic test_ready_at_timeout();
    m0_valid = 1'b1; m0_addr = 32'h600;
    #1;
    for (int i = 1; i <= 7; i++) tick();
    tick(); // N+8
    s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
    #1;
    n_checks++; if (m0_ready !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL race_ready: got ready=%b timeout=%b want 1 0", m0_ready, timeout); end
    n_checks++; if (m0_rdata !== 32'hCAFE_F00D || s_valid !== 1'b1) begin n_fail++; $display("FAIL race_rdata: got rdata=%h s_valid=%b want cafef00d 1", m0_rdata, s_valid); end
    tick();
    idle_inputs();
    #1;
  endtask

  task automatic test_valid_drop();
    m1_valid = 1'b1; m1_addr = 32'h700;
    #1;
    tick(); // N+1
    n_checks++; if (owner !== 1'b1 || s_valid !== 1'b1) begin n_fail++; $display("FAIL drop_grant: got owner=%b s_valid=%b want 1 1", owner, s_valid); end
    tick(); // N+2: master 1 withdraws
    m1_valid = 1'b0;
    #1;
    n_checks++; if (s_valid !== 1'b0 || m1_ready !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL drop_quiet: got s_valid=%b ready=%b timeout=%b want 0 0 0", s_valid, m1_ready, timeout); end
    m0_valid = 1'b1; m0_addr = 32'h680;
    tick(); // N+3 back in IDLE
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got s_valid=%b want 0", s_valid); end
    tick(); // N+4
    n_checks++; if (owner !== 1'b0 || s_valid !== 1'b1 || s_addr !== 32'h680) begin n_fail++; $display("FAIL drop_rearb: got owner=%b s_valid=%b addr=%h want 0 1 680", owner, s_valid, s_addr); end
    s_ready = 1'b1;
    #1;
    n_checks++; if (m0_ready !== 1'b1) begin n_fail++; $display("FAIL drop_rearb_done: got %b want 1", m0_ready); end
    tick();
    idle_inputs();
    #1;
  endtask

  task automatic test_reset_mid_busy();
    m1_valid = 1'b1; m1_addr = 32'h7A0; s_rdata = 32'h5555_5555;
    #1;
    tick(); // BUSY with master 1
    n_checks++; if (owner !== 1'b1 || s_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got owner=%b s_valid=%b want 1 1", owner, s_valid); end
    #2;
    rst_n = 1'b0; s_ready = 1'b1; m0_valid = 1'b1; m0_addr = 32'h7B0;
    #1; // no clock edge in between
    n_checks++; if (s_valid !== 1'b0 || s_addr !== 32'h0 || owner !== 1'b0) begin n_fail++; $display("FAIL mid_async: got s_valid=%b addr=%h owner=%b want 0 0 0", s_valid, s_addr, owner); end
    n_checks++; if (m1_ready !== 1'b0 || m1_rdata !== 32'h0 || m0_ready !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL mid_async_resp: got m1=%b/%h m0=%b to=%b want all 0", m1_ready, m1_rdata, m0_ready, timeout); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(); // first arbitration after reset, both requesting
    n_checks++; if (owner !== 1'b0 || s_valid !== 1'b1 || s_addr !== 32'h7B0) begin n_fail++; $display("FAIL post_rst_first: got owner=%b s_valid=%b addr=%h want 0 1 7b0", owner, s_valid, s_addr); end
    n_checks++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin n_fail++; $display("FAIL post_rst_ready: got m0=%b m1=%b want 1 0", m0_ready, m1_ready); end
    tick(); // IDLE bubble
    tick(); // master 1 next
    n_checks++; if (owner !== 1'b1 || m1_ready !== 1'b1 || m1_rdata !== 32'h5555_5555) begin n_fail++; $display("FAIL post_rst_second: got owner=%b ready=%b rdata=%h want 1 1 55555555", owner, m1_ready, m1_rdata); end
    tick();
    idle_inputs();
    #1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_m1_write();
    test_round_robin();
    test_timeout();
    test_ready_at_timeout();
    test_valid_drop();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard so the run can never hang
  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t want < 50000", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/picorv32_mem_arbiter.md
# picorv32_mem_arbiter

Two-master, one-slave arbiter for the PicoRV32 native memory interface (valid/ready, addr, wdata, wstrb, rdata). It shares the demo system's single memory/peripheral port between the CPU (master 0) and an auxiliary master such as a debug loader or DMA (master 1), with round-robin fairness. A watchdog completes any access the slave fails to acknowledge, so a hung peripheral cannot stall the CPU forever.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: slave response limit, counted in BUSY cycles; 0 disables the watchdog.
- TIMEOUT_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out access.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset. **Asynchronous, active-low.**
- m0_valid_i, m1_valid_i  in  1  access request; held until the matching ready.
- m0_instr_i, m1_instr_i  in  1  instruction-fetch flag.
- m0_addr_i, m1_addr_i  in  32  byte address.
- m0_wdata_i, m1_wdata_i  in  32  write data.
- m0_wstrb_i, m1_wstrb_i  in  4  byte write strobes; 0 means read.
- m0_ready_o, m1_ready_o  out  1  one-cycle completion pulse.
- m0_rdata_o, m1_rdata_o  out  32  read data, valid when the matching ready is high.
- s_valid_o, s_instr_o  out  1  request and instruction flag to the slave.
- s_addr_o  out  32  address to the slave.
- s_wdata_o  out  32  write data to the slave.
- s_wstrb_o  out  4  write strobes to the slave.
- s_ready_i  in  1  slave completion.
- s_rdata_i  in  32  slave read data.
- owner_o  out  1  registered grant; 0 = master 0, 1 = master 1.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE and BUSY. Registers: grant, last_grant, timeout counter.
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - grant=0; last_grant=1, so master 0 wins the first tie.
  - Counter=0.
  - All outputs 0.
- IDLE:
  - s_valid_o=0; both ready outputs are 0.
  - If any valid is high: choose the requester; when both request, choose the one ≠ last_grant.
  - Register grant and last_grant, clear the counter, and go to BUSY.
- BUSY:
  - s_* are a combinational mux of the granted master's inputs; s_valid_o = granted valid.
  - The granted master's rdata = s_rdata_i and ready = s_ready_i.
  - The non-granted master sees ready=0 and rdata=0.
- Completion: s_ready_i=1 in BUSY.
  - The granted ready pulses in the same cycle.
  - Next state is IDLE.
- Timeout: counter reaches TIMEOUT_CYCLES−1 with s_ready_i=0 (TIMEOUT_CYCLES≠0).
  - That cycle: granted ready=1, rdata=TIMEOUT_RDATA, timeout_o=1, s_valid_o forced to 0.
  - Next state is IDLE.
  - Any late s_ready_i is ignored.
- Simultaneous s_ready_i and timeout: normal completion wins; timeout_o stays 0 and rdata = s_rdata_i.
- Granted master drops valid in BUSY (protocol violation): return to IDLE next cycle; no ready, no timeout.
- The counter saturates and never wraps.
- owner_o = grant; it is held in IDLE.

## Timing
- Arbitration latency: a request first seen in IDLE at cycle N gives s_valid_o=1 at N+1.
- A zero-wait slave (s_ready_i combinational) completes at N+1; IDLE follows at N+2.
- Back-to-back throughput: 2 cycles per access minimum, because of one IDLE bubble per transfer.
- A master keeping valid high after its ready is treated as a new request in that IDLE.
- Timeout: ready arrives at N+TIMEOUT_CYCLES.
- All state updates happen on the rising edge of clk_i. Outputs are combinational from registered state plus the granted inputs; there is no combinational path between the two masters.

## Structure
- Shared package picorv32_demo_pkg holds:
  - the state encoding (ARB_IDLE=0, ARB_BUSY=1);
  - the default timeout and TIMEOUT_RDATA constants;
  - the master index constants.
- One natural sub-module, bus_watchdog: saturating counter with clear, enable and an expired output, parameterised by TIMEOUT_CYCLES. It is reusable by future peripheral bridges.

## Test plan
- Single master 0 read; slave answers after 3 wait cycles with 0x1234_5678 → s_valid_o at N+1; m0_ready_o pulses at N+4 with m0_rdata_o=0x1234_5678; m1_ready_o stays 0.
- Both masters request continuously; zero-wait slave → grants alternate 0,1,0,1; owner_o toggles every 2 cycles; no master is starved.
- Master 1 write, addr 0x100, wdata 0xA5A5_A5A5, wstrb 4'b0011 → these exact values appear on s_*; m1_ready_o pulses once.
- Slave never responds; TIMEOUT_CYCLES=8 → m0_ready_o and timeout_o pulse at N+8 with rdata 0xDEAD_BEEF; s_valid_o low in that cycle; next request is arbitrated normally.
- s_ready_i arrives in the timeout cycle → normal completion; timeout_o=0; rdata = s_rdata_i.
- rst_n_i asserted mid-BUSY → all outputs 0 immediately, without waiting for a clock edge; after release, simultaneous requests grant master 0 first.
